// File: rtl/gmii_tx_frame_arbiter.sv
// Round-robin arbiter that merges two byte-stream frame sources onto one GMII transmit port,
// adding preamble/SFD, flagging underrun/oversize with TX_ER and enforcing inter-packet gap.
module gmii_tx_frame_arbiter #(
    parameter int IPG_CYCLES = 12,
    parameter int MAX_LEN    = 1518
) (
    input  logic       GTX_CLK,
    input  logic       mr_main_reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    input  logic       transmitting,
    output logic [7:0] TXD,
    output logic       TX_EN,
    output logic       TX_ER,
    output logic [1:0] grant,
    output logic [7:0] err_count
);

    localparam int DATA_W = 8;
    localparam int LEN_W  = ($clog2(MAX_LEN + 2) > 11) ? $clog2(MAX_LEN + 2) : 11;
    localparam int IPG_W  = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;

    localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(MAX_LEN);
    localparam logic [IPG_W-1:0]  IPG_LAST = IPG_W'(IPG_CYCLES - 1);
    localparam logic [2:0]        PRE_LAST = 3'd6;
    localparam logic [DATA_W-1:0] PRE_BYTE = 8'h55;
    localparam logic [DATA_W-1:0] SFD_BYTE = 8'hD5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_SFD,
        S_DATA,
        S_DRAIN,
        S_IPG
    } state_t;

    state_t            state, state_nxt;
    logic [1:0]        grant_nxt;
    logic              last_src, last_src_nxt;
    logic [2:0]        pre_cnt, pre_cnt_nxt;
    logic [LEN_W-1:0]  len_cnt, len_cnt_nxt;
    logic [IPG_W-1:0]  ipg_cnt, ipg_cnt_nxt;
    logic [7:0]        err_nxt;
    logic [DATA_W-1:0] txd_nxt;
    logic              tx_en_nxt;
    logic              tx_er_nxt;

    logic              sel_valid;
    logic              sel_last;
    logic [DATA_W-1:0] sel_data;
    logic              pick1;
    logic              fwd_phase;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Ready is combinational so a byte is taken on the same edge it is forwarded.
    assign fwd_phase  = (state == S_DATA) || (state == S_DRAIN);
    assign req0_ready = fwd_phase && grant[0];
    assign req1_ready = fwd_phase && grant[1];

    assign sel_valid  = grant[1] ? req1_valid : req0_valid;
    assign sel_last   = grant[1] ? req1_last  : req0_last;
    assign sel_data   = grant[1] ? req1_data  : req0_data;

    // last_src holds the source served most recently; on a tie the other one wins.
    assign pick1      = (req0_valid && req1_valid) ? ~last_src : req1_valid;

    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        last_src_nxt = last_src;
        pre_cnt_nxt  = pre_cnt;
        len_cnt_nxt  = len_cnt;
        ipg_cnt_nxt  = ipg_cnt;
        err_nxt      = err_count;
        txd_nxt      = '0;
        tx_en_nxt    = 1'b0;
        tx_er_nxt    = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (req0_valid || req1_valid) begin
                    grant_nxt   = pick1 ? 2'b10 : 2'b01;
                    pre_cnt_nxt = '0;
                    len_cnt_nxt = '0;
                    state_nxt   = S_PRE;
                end
            end

            S_PRE: begin
                tx_en_nxt = 1'b1;
                txd_nxt   = PRE_BYTE;
                if (pre_cnt == PRE_LAST) begin
                    state_nxt = S_SFD;
                end else begin
                    pre_cnt_nxt = pre_cnt + 3'd1;
                end
            end

            S_SFD: begin
                tx_en_nxt = 1'b1;
                txd_nxt   = SFD_BYTE;
                state_nxt = S_DATA;
            end

            S_DATA: begin
                tx_en_nxt = 1'b1;
                if (!sel_valid) begin
                    tx_er_nxt = 1'b1;
                    err_nxt   = sat_inc8(err_count);
                    state_nxt = S_DRAIN;
                end else if (len_cnt == LEN_MAX) begin
                    // Byte MAX_LEN+1 is swallowed; a last flag on it ends the frame here.
                    tx_er_nxt = 1'b1;
                    err_nxt   = sat_inc8(err_count);
                    if (sel_last) begin
                        ipg_cnt_nxt  = '0;
                        len_cnt_nxt  = '0;
                        last_src_nxt = grant[1];
                        state_nxt    = S_IPG;
                    end else begin
                        state_nxt = S_DRAIN;
                    end
                end else begin
                    txd_nxt     = sel_data;
                    len_cnt_nxt = len_cnt + 1'b1;
                    if (sel_last) begin
                        ipg_cnt_nxt  = '0;
                        len_cnt_nxt  = '0;
                        last_src_nxt = grant[1];
                        state_nxt    = S_IPG;
                    end
                end
            end

            S_DRAIN: begin
                if (sel_valid && sel_last) begin
                    ipg_cnt_nxt  = '0;
                    len_cnt_nxt  = '0;
                    last_src_nxt = grant[1];
                    state_nxt    = S_IPG;
                end
            end

            S_IPG: begin
                len_cnt_nxt = '0;
                if ((ipg_cnt == IPG_LAST) && !transmitting) begin
                    grant_nxt = 2'b00;
                    state_nxt = S_IDLE;
                end else if (ipg_cnt != IPG_LAST) begin
                    ipg_cnt_nxt = ipg_cnt + 1'b1;
                end
            end

            default: begin
                grant_nxt = 2'b00;
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            state     <= S_IDLE;
            grant     <= 2'b00;
            last_src  <= 1'b1;
            pre_cnt   <= '0;
            len_cnt   <= '0;
            ipg_cnt   <= '0;
            err_count <= 8'h00;
            TXD       <= '0;
            TX_EN     <= 1'b0;
            TX_ER     <= 1'b0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            last_src  <= last_src_nxt;
            pre_cnt   <= pre_cnt_nxt;
            len_cnt   <= len_cnt_nxt;
            ipg_cnt   <= ipg_cnt_nxt;
            err_count <= err_nxt;
            TXD       <= txd_nxt;
            TX_EN     <= tx_en_nxt;
            TX_ER     <= tx_er_nxt;
        end
    end

endmodule
